// File: rtl/datapath_unit.sv
// datapath_unit: processor datapath driven by controller_fsm.
// Holds PC, IR, a 16-entry register file, the accumulator, the ALU and the C flag.
// Instructions are 8 bits: [7:4] opcode, [3:0] register index or immediate.
// Optional build macro DATAPATH_R0_ZERO_EN: when defined, R0 reads as zero on
// every path and writes to R0 are dropped. When undefined, R0 is an ordinary register.
module datapath_unit #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              LoadIR,
    input  logic              IncPC,
    input  logic              SelPC,
    input  logic              LoadPC,
    input  logic              LoadReg,
    input  logic              LoadAcc,
    input  logic [1:0]        SelAcc,
    input  logic [3:0]        SelALU,
    input  logic [7:0]        InstrData,
    output logic [ADDR_W-1:0] InstrAddr,
    output logic [3:0]        Opcode,
    output logic              Z,
    output logic              C,
    output logic [DATA_W-1:0] AccOut
);

    // ALU operation encodings; they match the instruction opcodes
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_SHFL = 4'b1011;
    localparam logic [3:0] OP_SHFR = 4'b1100;

    // Accumulator source select
    typedef enum logic [1:0] {
        ACC_ALU  = 2'b00,
        ACC_REG  = 2'b01,
        ACC_IMM  = 2'b10,
        ACC_HOLD = 2'b11
    } accSel_t;

    logic [ADDR_W-1:0] pcReg;
    logic [7:0]        irReg;
    logic [DATA_W-1:0] accReg;
    logic              cFlag;
    logic [DATA_W-1:0] regFile [16];

    logic [3:0]        regIdx;
    logic [DATA_W-1:0] regRead;
    logic              regWriteEn;
    logic [DATA_W-1:0] immData;
    logic [ADDR_W-1:0] pcNext;

    logic [DATA_W-1:0] aluResult;
    logic              aluCarry;
    logic [DATA_W:0]   addSum;

    assign regIdx  = irReg[3:0];
    assign immData = DATA_W'(regIdx);

`ifdef DATAPATH_R0_ZERO_EN
    // R0 is hardwired to zero: reads return 0 and writes are discarded
    assign regRead    = (regIdx == 4'd0) ? '0 : regFile[regIdx];
    assign regWriteEn = LoadReg && (regIdx != 4'd0);
`else
    assign regRead    = regFile[regIdx];
    assign regWriteEn = LoadReg;
`endif

    // PC load source: immediate field or low bits of the indexed register
    assign pcNext = SelPC ? ADDR_W'(regIdx) : ADDR_W'(regRead);

    assign addSum = {1'b0, regRead} + {1'b0, accReg};

    // ALU: A = indexed register, B = accumulator
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred
        aluResult = accReg;
        aluCarry  = cFlag;
        case (SelALU)
            OP_ADD: begin
                aluResult = addSum[DATA_W-1:0];
                aluCarry  = addSum[DATA_W];
            end
            OP_SUB: begin
                aluResult = regRead - accReg;
                aluCarry  = (regRead < accReg);
            end
            OP_NOR: begin
                aluResult = ~(regRead | accReg);
                aluCarry  = 1'b0;
            end
            OP_SHFR: begin
                aluResult = accReg >> 1;
                aluCarry  = accReg[0];
            end
            OP_SHFL: begin
                aluResult = accReg << 1;
                aluCarry  = accReg[DATA_W-1];
            end
            default: begin
                aluResult = accReg;
                aluCarry  = cFlag;
            end
        endcase
    end

    // Program counter: load has priority over increment; increment wraps naturally
    always_ff @(posedge Clk or posedge reset) begin
        // NOTE: non-blocking assignments so every same-edge reader sees pre-edge state
        if (reset) begin
            pcReg <= '0;
        end else if (LoadPC) begin
            pcReg <= pcNext;
        end else if (IncPC) begin
            pcReg <= pcReg + ADDR_W'(1);
        end
    end

    // Instruction register: captures memory data addressed by the pre-edge PC
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            irReg <= '0;
        end else if (LoadIR) begin
            irReg <= InstrData;
        end
    end

    // Accumulator and carry flag; carry only follows the ALU path
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            accReg <= '0;
            cFlag  <= 1'b0;
        end else if (LoadAcc) begin
            case (accSel_t'(SelAcc))
                ACC_ALU: begin
                    accReg <= aluResult;
                    cFlag  <= aluCarry;
                end
                ACC_REG:  accReg <= regRead;
                ACC_IMM:  accReg <= immData;
                ACC_HOLD: accReg <= accReg;
                default:  accReg <= accReg;
            endcase
        end
    end

    // Register file write: always stores the pre-edge accumulator
    always_ff @(posedge Clk or posedge reset) begin
        // NOTE: the register file is cleared by reset, so it maps to flops rather than a RAM macro
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                regFile[i] <= '0;
            end
        end else if (regWriteEn) begin
            regFile[regIdx] <= accReg;
        end
    end

    assign InstrAddr = pcReg;
    assign Opcode    = irReg[7:4];
    assign Z         = (accReg == '0);
    assign C         = cFlag;
    assign AccOut    = accReg;

endmodule
